// File: rtl/axi_master_burst.sv
// Single-outstanding AXI4 burst master: one command at a time, AW/W issued together,
// read/write beats streamed through with per-beat backpressure and error detection.
module axi_master_burst #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    done_o,
  output logic [1:0]              resp_o,
  output logic                    err_o,
  output logic [ID_WIDTH-1:0]     AWID,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [ID_WIDTH-1:0]     BID,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ID_WIDTH-1:0]     ARID,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [7:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [ID_WIDTH-1:0]     RID,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam logic [2:0] SIZE = 3'($clog2(DATA_WIDTH/8));
  localparam int CW = LEN_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WRESP, S_RADDR, S_RDATA, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [CW-1:0]           cnt;
  logic                    aw_valid_q, ar_valid_q, aw_done, w_done;
  logic [1:0]              resp_acc, resp_nxt, resp_q;
  logic                    err_acc, err_nxt, err_q;
  logic                    accept, aw_hs, w_hs, ar_hs, r_hs, w_active, r_active;
  logic                    len_hit, r_over;

  // EXOKAY counts as OKAY when picking the worst read response
  function automatic logic [1:0] rank(input logic [1:0] r);
    return (r == 2'b01) ? 2'b00 : r;
  endfunction

  assign accept   = (state == S_IDLE) && cmd_valid;
  assign w_active = (state == S_WR) && !w_done;
  assign r_active = (state == S_RDATA);
  assign len_hit  = (cnt == {1'b0, len_q});
  assign r_over   = (cnt > {1'b0, len_q});

  assign cmd_ready = (state == S_IDLE);
  assign AWID    = id_q;
  assign AWADDR  = addr_q;
  assign AWLEN   = 8'(len_q);
  assign AWSIZE  = SIZE;
  assign AWBURST = 2'b01;
  assign AWVALID = aw_valid_q;
  assign ARID    = id_q;
  assign ARADDR  = addr_q;
  assign ARLEN   = 8'(len_q);
  assign ARSIZE  = SIZE;
  assign ARBURST = 2'b01;
  assign ARVALID = ar_valid_q;

  assign WVALID   = w_active && wr_valid;
  assign wr_ready = w_active && WREADY;
  assign WDATA    = wr_data;
  assign WSTRB    = wr_strb;
  assign WLAST    = len_hit;
  assign BREADY   = (state == S_WRESP);

  assign rd_valid = r_active && RVALID;
  assign RREADY   = r_active && rd_ready;
  assign rd_data  = RDATA;
  assign rd_last  = RLAST;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = rd_valid && rd_ready;

  assign done_o = (state == S_DONE);
  assign resp_o = resp_q;
  assign err_o  = err_q;

  always_comb begin
    state_nxt = state;
    resp_nxt  = resp_acc;
    err_nxt   = err_acc;
    case (state)
      S_IDLE: if (cmd_valid) begin
        state_nxt = cmd_write ? S_WR : S_RADDR;
        resp_nxt  = '0;
        err_nxt   = 1'b0;
      end
      // AW and the last W beat may complete in either order or together
      S_WR: if ((aw_done || aw_hs) && (w_done || (w_hs && WLAST)))
        state_nxt = S_WRESP;
      S_WRESP: if (BVALID) begin
        resp_nxt  = BRESP;
        err_nxt   = err_acc | (BID != id_q);
        state_nxt = S_DONE;
      end
      S_RADDR: if (ar_hs) state_nxt = S_RDATA;
      S_RDATA: if (r_hs) begin
        if (rank(RRESP) > rank(resp_acc)) resp_nxt = RRESP;
        err_nxt = err_acc | (RID != id_q) | (RLAST && !len_hit) | (!RLAST && r_over);
        if (RLAST || r_over) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= S_IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt        <= '0;
      aw_valid_q <= 1'b0;
      ar_valid_q <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_acc   <= '0;
      err_acc    <= 1'b0;
      resp_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state    <= state_nxt;
      resp_acc <= resp_nxt;
      err_acc  <= err_nxt;
      if (state_nxt == S_DONE) begin
        resp_q <= resp_nxt;
        err_q  <= err_nxt;
      end
      if (accept) begin
        id_q       <= cmd_id;
        addr_q     <= cmd_addr;
        len_q      <= cmd_len;
        cnt        <= '0;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
        aw_valid_q <= cmd_write;
        ar_valid_q <= !cmd_write;
      end else begin
        if (aw_hs) begin
          aw_valid_q <= 1'b0;
          aw_done    <= 1'b1;
        end
        if (ar_hs) ar_valid_q <= 1'b0;
        if (w_hs && WLAST) w_done <= 1'b1;
        if (w_hs || r_hs) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_master_burst.sv
// Directed bench for axi_master_burst: writes, reads, protocol errors, reset mid-burst, 64-bit sizing.
module tb_axi_master_burst;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_id;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done_o, err_o;
  logic [1:0]  resp_o;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [3:0]  WSTRB;

  // outputs of the 64-bit instance
  logic        x_cmd_ready, x_wr_ready, x_rd_valid, x_rd_last, x_done, x_err;
  logic [1:0]  x_resp, x_awburst, x_arburst;
  logic [63:0] x_rd_data, x_wdata;
  logic [3:0]  x_awid, x_arid;
  logic [31:0] x_awaddr, x_araddr;
  logic [7:0]  x_awlen, x_arlen, x_wstrb;
  logic [2:0]  x_awsize, x_arsize;
  logic        x_awvalid, x_wlast, x_wvalid, x_bready, x_arvalid, x_rready;

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;
  int exp_dones = 0;

  always #5 ACLK = ~ACLK;
  always @(negedge ACLK) if (done_o === 1'b1) done_cnt++;

  axi_master_burst #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done_o(done_o), .resp_o(resp_o), .err_o(err_o),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  axi_master_burst #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(64), .LEN_WIDTH(8)) dut64 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(1'b0), .cmd_ready(x_cmd_ready), .cmd_write(1'b0),
    .cmd_addr(32'h0), .cmd_len(8'h0), .cmd_id(4'h0),
    .wr_valid(1'b0), .wr_ready(x_wr_ready), .wr_data(64'h0123_4567_89AB_CDEF), .wr_strb(8'hA5),
    .rd_valid(x_rd_valid), .rd_ready(1'b0), .rd_data(x_rd_data), .rd_last(x_rd_last),
    .done_o(x_done), .resp_o(x_resp), .err_o(x_err),
    .AWID(x_awid), .AWADDR(x_awaddr), .AWLEN(x_awlen), .AWSIZE(x_awsize), .AWBURST(x_awburst),
    .AWVALID(x_awvalid), .AWREADY(1'b0),
    .WDATA(x_wdata), .WSTRB(x_wstrb), .WLAST(x_wlast), .WVALID(x_wvalid), .WREADY(1'b0),
    .BID(4'h0), .BRESP(2'b00), .BVALID(1'b0), .BREADY(x_bready),
    .ARID(x_arid), .ARADDR(x_araddr), .ARLEN(x_arlen), .ARSIZE(x_arsize), .ARBURST(x_arburst),
    .ARVALID(x_arvalid), .ARREADY(1'b0),
    .RID(4'h0), .RDATA(64'h0), .RRESP(2'b00), .RLAST(1'b0), .RVALID(1'b0), .RREADY(x_rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                       input logic [3:0] id);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  // called at the negedge of the DONE cycle
  task automatic finish_txn(input string tag, input logic [1:0] rsp, input logic err);
    exp_dones++;
    #1;
    check({tag, "_done"}, 64'(done_o), 64'd1);
    check({tag, "_resp"}, 64'(resp_o), 64'(rsp));
    check({tag, "_err"},  64'(err_o),  64'(err));
    @(negedge ACLK); #1;
    check({tag, "_done_pulse"}, 64'(done_o), 64'd0);
    check({tag, "_idle_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_done_count"}, 64'(done_cnt), 64'(exp_dones));
  endtask

  initial begin
    int beat;
    ARESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    wr_valid = 1'b0; wr_data = '0; wr_strb = 4'hF; rd_ready = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BID = '0; BRESP = '0; BVALID = 1'b0;
    ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
    repeat (3) @(negedge ACLK);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_awvalid",   64'(AWVALID), 64'd0);
    check("rst_arvalid",   64'(ARVALID), 64'd0);
    check("rst_bready",    64'(BREADY), 64'd0);
    check("rst_awsize",    64'(AWSIZE), 64'd2);
    check("rst_awburst",   64'(AWBURST), 64'd1);
    check("rst_awaddr",    64'(AWADDR), 64'd0);
    check("rst_resp",      64'(resp_o), 64'd0);
    check("rst_err",       64'(err_o), 64'd0);
    check("w64_awsize",    64'(x_awsize), 64'd3);
    check("w64_arsize",    64'(x_arsize), 64'd3);
    check("w64_wstrb",     64'(x_wstrb), 64'hA5);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);

    // write len=3, AW accepted immediately, continuous W
    AWREADY = 1'b1; WREADY = 1'b1; wr_valid = 1'b1;
    issue(1'b1, 32'h100, 8'd3, 4'd5);
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'hA0 + i;
      #1;
      if (i == 0) begin
        check("w1_awvalid", 64'(AWVALID), 64'd1);
        check("w1_awaddr",  64'(AWADDR), 64'h100);
        check("w1_awlen",   64'(AWLEN), 64'd3);
        check("w1_awid",    64'(AWID), 64'd5);
        check("w1_cmd_busy", 64'(cmd_ready), 64'd0);
      end else begin
        check("w1_awvalid_dropped", 64'(AWVALID), 64'd0);
      end
      check("w1_wvalid", 64'(WVALID), 64'd1);
      check("w1_wdata",  64'(WDATA), 64'(32'hA0 + i));
      check("w1_wlast",  64'(WLAST), 64'(i == 3));
      @(negedge ACLK);
    end
    wr_valid = 1'b0;
    #1;
    check("w1_bready", 64'(BREADY), 64'd1);
    BVALID = 1'b1; BID = 4'd5; BRESP = 2'b00;
    @(negedge ACLK);
    BVALID = 1'b0;
    finish_txn("w1", 2'b00, 1'b0);

    // write len=1, W finishes before AW, AW stalled, BID mismatch
    AWREADY = 1'b0; wr_valid = 1'b1; wr_data = 32'h55;
    issue(1'b1, 32'h340, 8'd1, 4'd2);
    for (int c = 1; c <= 5; c++) begin
      #1;
      check("w2_awvalid_hold", 64'(AWVALID), 64'd1);
      check("w2_awaddr_hold",  64'(AWADDR), 64'h340);
      check("w2_no_bready",    64'(BREADY), 64'd0);
      if (c == 2) check("w2_wlast", 64'(WLAST), 64'd1);
      if (c >= 3) check("w2_wvalid_gated", 64'(WVALID), 64'd0);
      if (c == 5) AWREADY = 1'b1;
      @(negedge ACLK);
    end
    wr_valid = 1'b0;
    #1;
    check("w2_bready", 64'(BREADY), 64'd1);
    check("w2_awvalid_clr", 64'(AWVALID), 64'd0);
    BVALID = 1'b1; BID = 4'd7; BRESP = 2'b00;
    @(negedge ACLK);
    BVALID = 1'b0;
    finish_txn("w2", 2'b00, 1'b1);

    // read len=7 id=3, rd_ready toggling, SLVERR on beat 4
    ARREADY = 1'b1;
    issue(1'b0, 32'h200, 8'd7, 4'd3);
    #1;
    check("r1_arvalid", 64'(ARVALID), 64'd1);
    check("r1_araddr",  64'(ARADDR), 64'h200);
    check("r1_arlen",   64'(ARLEN), 64'd7);
    check("r1_arid",    64'(ARID), 64'd3);
    check("r1_arsize",  64'(ARSIZE), 64'd2);
    beat = 0;
    for (int k = 0; k < 40 && beat < 8; k++) begin
      @(negedge ACLK);
      rd_ready = (k % 2 == 0);
      RVALID = 1'b1; RID = 4'd3; RDATA = 32'hB0 + beat;
      RLAST = (beat == 7); RRESP = (beat == 4) ? 2'b10 : 2'b00;
      #1;
      check("r1_rready", 64'(RREADY), 64'(rd_ready));
      check("r1_rd_valid", 64'(rd_valid), 64'd1);
      if (rd_ready) begin
        check("r1_rd_data", 64'(rd_data), 64'(32'hB0 + beat));
        check("r1_rd_last", 64'(rd_last), 64'(beat == 7));
        beat++;
      end
    end
    check("r1_beats", 64'(beat), 64'd8);
    @(negedge ACLK);
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
    finish_txn("r1", 2'b10, 1'b0);

    // read len=3, RLAST early on beat index 2
    rd_ready = 1'b1;
    issue(1'b0, 32'h400, 8'd3, 4'd4);
    for (int b = 0; b < 3; b++) begin
      @(negedge ACLK);
      RVALID = 1'b1; RID = 4'd4; RDATA = 32'hC0 + b; RLAST = (b == 2);
    end
    @(negedge ACLK);
    RVALID = 1'b0; RLAST = 1'b0;
    finish_txn("r2", 2'b00, 1'b1);

    // read len=0 with RID mismatch
    issue(1'b0, 32'h500, 8'd0, 4'd1);
    @(negedge ACLK);
    RVALID = 1'b1; RID = 4'd6; RLAST = 1'b1; RDATA = 32'hD0;
    @(negedge ACLK);
    RVALID = 1'b0; RLAST = 1'b0;
    finish_txn("r3", 2'b00, 1'b1);

    // reset asserted during the third read beat
    issue(1'b0, 32'h600, 8'd3, 4'd2);
    for (int b = 0; b < 2; b++) begin
      @(negedge ACLK);
      RVALID = 1'b1; RID = 4'd2; RDATA = 32'hE0 + b; RLAST = 1'b0;
    end
    @(negedge ACLK);
    #1;
    check("rst_mid_rd_valid", 64'(rd_valid), 64'd1);
    ARESETn = 1'b0;
    #1;
    check("rst_mid_rready",    64'(RREADY), 64'd0);
    check("rst_mid_rd_valid0", 64'(rd_valid), 64'd0);
    check("rst_mid_arvalid",   64'(ARVALID), 64'd0);
    check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_mid_err",       64'(err_o), 64'd0);
    check("rst_mid_done",      64'(done_o), 64'd0);
    @(negedge ACLK);
    ARESETn = 1'b1; RVALID = 1'b0;
    @(negedge ACLK);

    // single-beat write after reset, EXOKAY response
    AWREADY = 1'b1; WREADY = 1'b1; wr_valid = 1'b1; wr_data = 32'hF00D; wr_strb = 4'h3;
    issue(1'b1, 32'h80, 8'd0, 4'd9);
    #1;
    check("w3_awvalid", 64'(AWVALID), 64'd1);
    check("w3_awid",    64'(AWID), 64'd9);
    check("w3_wlast",   64'(WLAST), 64'd1);
    check("w3_wstrb",   64'(WSTRB), 64'h3);
    @(negedge ACLK);
    wr_valid = 1'b0;
    #1;
    check("w3_bready", 64'(BREADY), 64'd1);
    BVALID = 1'b1; BID = 4'd9; BRESP = 2'b01;
    @(negedge ACLK);
    BVALID = 1'b0;
    finish_txn("w3", 2'b01, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_master_burst.md
Name: axi_master_burst

Overview:
Parametrised single-outstanding AXI4 burst master, successor to the fixed-pattern command master. Takes commands on a valid/ready interface and streams write beats in and read beats out with per-beat backpressure. Issues AW and W concurrently and derives AxSIZE and WSTRB width from DATA_WIDTH. Accumulates the worst-case response and detects ID and burst-length protocol errors. Sits between a DMA/test sequencer and the AXI interconnect.

Parameters:
ID_WIDTH, 4, width of AxID/xID and cmd_id
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data bus width; power of two, 8..1024
LEN_WIDTH, 8, AxLEN width (beats-1); fixed 8 for AXI4

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
cmd_valid/cmd_ready  in/out  1/1  command handshake
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  start address, must be size-aligned
cmd_len  in  LEN_WIDTH  beats-1
cmd_id  in  ID_WIDTH  transaction ID
wr_valid/wr_ready  in/out  1/1  write-beat stream handshake
wr_data/wr_strb  in  DATA_WIDTH/DATA_WIDTH/8  write beat payload
rd_valid/rd_ready  out/in  1/1  read-beat stream handshake
rd_data/rd_last  out  DATA_WIDTH/1  read beat payload, last flag
done_o  out  1  one-cycle pulse at transaction end
resp_o  out  2  worst response of last transaction
err_o  out  1  ID mismatch or length error in last transaction
AW: AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID out, AWREADY in (ID_WIDTH/ADDR_WIDTH/8/3/2/1/1)
W: WDATA/WSTRB/WLAST/WVALID out, WREADY in (DATA_WIDTH/DATA_WIDTH/8/1/1/1)
B: BID/BRESP/BVALID in, BREADY out (ID_WIDTH/2/1/1)
AR: ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID out, ARREADY in (as AW)
R: RID/RDATA/RRESP/RLAST/RVALID in, RREADY out (ID_WIDTH/DATA_WIDTH/2/1/1/1)

Behaviour:
- Reset (async, any state): state IDLE; every VALID/READY, done_o, err_o, rd_valid, wr_ready low; resp_o=0; counters=0; cmd_ready=1. AxADDR/AxLEN/AxID=0, AxSIZE=log2(DATA_WIDTH/8), AxBURST=2'b01.
- States: IDLE, WR (AW+W), WRESP, RADDR, RDATA, DONE.
- IDLE: cmd_ready=1. On cmd_valid: latch addr/len/id into both AW and AR registers, clear beat counter, resp accumulator, err flag and aw_done. Next state WR if cmd_write, else RADDR. cmd_ready=0 in every other state.
- WR: AWVALID registered; it rises the cycle after accept and holds until the AWREADY handshake, which sets aw_done. W is combinational pass-through: WVALID=wr_valid, wr_ready=WREADY, WDATA/WSTRB=wr_data/wr_strb, WLAST=(wcnt==AWLEN). wcnt increments per W handshake. W beats may precede, coincide with, or follow the AW handshake. Leave when aw_done (or AW handshake this cycle) and the WLAST handshake have both occurred, in either order or the same cycle.
- WRESP: BREADY=1. On BVALID: resp=BRESP; err if BID!=latched id; then DONE.
- RADDR: ARVALID held until ARREADY, then RDATA.
- RDATA: pass-through with rd_valid=RVALID, RREADY=rd_ready, rd_data=RDATA, rd_last=RLAST. Per handshake: rcnt++ and resp=max(resp,RRESP), with EXOKAY (01) ranked as OKAY.
- Read errors: RID mismatch sets err. An RLAST beat with rcnt!=ARLEN sets err. A beat beyond ARLEN without RLAST sets err and forces exit. Exit to DONE on the RLAST handshake or on the forced exit.
- DONE: done_o=1 for exactly one cycle, then IDLE. resp_o/err_o update in DONE and hold until the next DONE.
- AXI stability: once asserted, AxVALID and address/control hold until the handshake; latched registers do not change outside IDLE.
- cmd_len=0: single beat; WLAST asserts on the first W beat.
- 4KB crossing is not checked; the caller's responsibility.

Test Plan:
- Write len=3 addr=0x100, AWREADY on the 1st cycle, wr_valid continuous, BRESP=00 -> 4 W beats, WLAST only on the 4th, AWSIZE=2, AWBURST=01, done_o one pulse, resp_o=00, err_o=0.
- Write len=1 with both W beats accepted before AWREADY (AW stalled 5 cycles) -> AWVALID/AWADDR stable throughout, WRESP entered only after AW handshake, done_o once.
- Read len=7 id=3, rd_ready toggling 1010..., RRESP beat 4=10 -> RREADY mirrors rd_ready, 8 beats out in order, rd_last on the 8th, resp_o=10.
- Read len=3, slave asserts RLAST on beat 2 -> done_o after that beat, err_o=1; BID/RID mismatch on a write/read -> err_o=1.
- ARESETn low during RDATA beat 2 -> all VALID/READY low immediately; after release cmd_ready=1, next command runs normally.
- DATA_WIDTH=64 instance -> AWSIZE/ARSIZE=3, WSTRB 8 bits passed through.
